// File: rtl/dma_job_arbiter.sv
// Round-robin arbiter that serialises per-requester DMA jobs onto a single shim job port.
// Optional watchdog on CLR/WAIT enabled by defining DMA_ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | arbitrate; a winner is accepted and its descriptor latched
// START   | one-cycle start pulse to the shim
// CLR     | wait for the stale done level to drop (bounded by CLR_WAIT_MAX)
// WAIT    | wait for done to rise
// RESP    | one-cycle completion pulse to the granted requester
module dma_job_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int CLR_WAIT_MAX   = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_dir,
  input  logic [NUM_REQ*32-1:0]   req_addr,
  input  logic [NUM_REQ*30-1:0]   req_len,
  output logic [NUM_REQ-1:0]      resp_done,
  output logic                    resp_err,
  output logic                    busy,
  output logic [15:0]             job_count,
  output logic                    dma_start_transfer,
  output logic                    dma_direction,
  output logic [31:0]             dma_ddr_addr,
  output logic [29:0]             dma_length_bytes,
`ifdef DMA_ARB_TIMEOUT_EN
  output logic                    timeout_hit,
`endif
  input  logic                    dma_transfer_done
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_CLR, S_WAIT, S_RESP} state_t;

  localparam int CW = $clog2(CLR_WAIT_MAX + 1);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_gnt;
  logic [ID_W-1:0]   win_id;
  logic              win_found;
  logic              sel_dir;
  logic [31:0]       sel_addr;
  logic [29:0]       sel_len;
  logic [CW-1:0]     clr_cnt;
  logic              err_q;
  logic              err_set;
  logic              wd_hit;

`ifdef DMA_ARB_TIMEOUT_EN
  logic [31:0] wd_cnt;
  assign wd_hit = ((state_q == S_CLR) || (state_q == S_WAIT)) && (wd_cnt == 32'd0);
`else
  assign wd_hit = 1'b0;
`endif

  // Search starts one past the last grant so every valid requester is served in turn.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      logic [ID_W-1:0] idx_w;
      idx = int'(last_gnt) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = ID_W'(idx);
      if (!win_found && req_valid[idx_w]) begin
        win_found = 1'b1;
        win_id    = idx_w;
      end
    end
  end

  always_comb begin
    sel_dir  = 1'b0;
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == ID_W'(i)) begin
        sel_dir  = req_dir[i];
        sel_addr = req_addr[32*i +: 32];
        sel_len  = req_len[30*i +: 30];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    case (state_q)
      S_IDLE:  if (win_found) state_d = S_START;
      S_START: state_d = S_CLR;
      S_CLR: begin
        if (!dma_transfer_done) begin
          state_d = S_WAIT;
        end else if (clr_cnt == '0) begin
          state_d = S_RESP;
          err_set = 1'b1;
        end
      end
      S_WAIT:  if (dma_transfer_done) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (wd_hit) begin
      state_d = S_RESP;
      err_set = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_gnt         <= ID_W'(NUM_REQ - 1);
      busy             <= 1'b0;
      job_count        <= '0;
      dma_direction    <= 1'b0;
      dma_ddr_addr     <= '0;
      dma_length_bytes <= '0;
      clr_cnt          <= '0;
      err_q            <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && win_found) begin
        last_gnt         <= win_id;
        busy             <= 1'b1;
        dma_direction    <= sel_dir;
        dma_ddr_addr     <= sel_addr;
        dma_length_bytes <= sel_len;
      end
      if (state_q == S_START)
        clr_cnt <= CW'(CLR_WAIT_MAX - 1);
      else if ((state_q == S_CLR) && (clr_cnt != '0))
        clr_cnt <= clr_cnt - 1'b1;
      if ((state_q != S_RESP) && (state_d == S_RESP))
        err_q <= err_set;
      if (state_q == S_RESP) begin
        busy      <= 1'b0;
        job_count <= job_count + 16'd1;
      end
    end
  end

`ifdef DMA_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt      <= '0;
      timeout_hit <= 1'b0;
    end else begin
      if (state_q == S_START)
        wd_cnt <= 32'(TIMEOUT_CYCLES - 1);
      else if (((state_q == S_CLR) || (state_q == S_WAIT)) && (wd_cnt != 32'd0))
        wd_cnt <= wd_cnt - 32'd1;
      if (wd_hit)
        timeout_hit <= 1'b1;
    end
  end
`endif

  assign dma_start_transfer = (state_q == S_START);
  assign resp_err           = (state_q == S_RESP) && err_q;

  // req_ready is combinational so the strobe lands in the acceptance cycle; masked during reset.
  always_comb begin
    req_ready = '0;
    resp_done = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = resetn && (state_q == S_IDLE) && win_found && (win_id == ID_W'(i));
      resp_done[i] = (state_q == S_RESP) && (last_gnt == ID_W'(i));
    end
  end

endmodule

// File: tb/tb_dma_job_arbiter.sv
// Directed bench for dma_job_arbiter with a small behavioural model of the shim done level.
module tb_dma_job_arbiter;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   req_dir = '0;
  logic [NR*32-1:0] req_addr = '0;
  logic [NR*30-1:0] req_len = '0;
  logic [NR-1:0]   resp_done;
  logic            resp_err;
  logic            busy;
  logic [15:0]     job_count;
  logic            dma_start_transfer;
  logic            dma_direction;
  logic [31:0]     dma_ddr_addr;
  logic [29:0]     dma_length_bytes;
  logic            dma_transfer_done = 1'b0;
`ifdef DMA_ARB_TIMEOUT_EN
  logic            timeout_hit;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int shim_mode = 0;
  int rise_at = 20;
  int sc = 0;
  bit running = 1'b0;

  dma_job_arbiter #(.NUM_REQ(NR), .ID_W(2), .CLR_WAIT_MAX(8), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
    .req_addr(req_addr), .req_len(req_len),
    .resp_done(resp_done), .resp_err(resp_err), .busy(busy), .job_count(job_count),
    .dma_start_transfer(dma_start_transfer), .dma_direction(dma_direction),
    .dma_ddr_addr(dma_ddr_addr), .dma_length_bytes(dma_length_bytes),
`ifdef DMA_ARB_TIMEOUT_EN
    .timeout_hit(timeout_hit),
`endif
    .dma_transfer_done(dma_transfer_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shim model: mode 0 drops done 3 cycles after start and raises it at rise_at,
  // mode 1 never changes done, mode 2 drops it and never raises it again.
  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      dma_transfer_done = 1'b0;
      running = 1'b0;
    end else if (dma_start_transfer) begin
      sc = 0;
      running = 1'b1;
    end else if (running) begin
      sc++;
      if (sc == 3 && shim_mode != 1) dma_transfer_done = 1'b0;
      if (sc == rise_at && shim_mode == 0) begin
        dma_transfer_done = 1'b1;
        running = 1'b0;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // which: 0 = any req_ready, 1 = start, 2 = any resp_done; n = cycles stepped
  task automatic wait_sig(input int which, input int budget, output int n);
    bit hit;
    n = 0;
    hit = 1'b0;
    #1;
    while (!hit && n <= budget) begin
      if ((which == 0 && req_ready != '0) || (which == 1 && dma_start_transfer) ||
          (which == 2 && resp_done != '0)) hit = 1'b1;
      else begin
        step;
        n++;
      end
    end
    if (!hit) begin
      checks++;
      failures++;
      $error("FAIL wait_timeout which=%0d observed=none expected=event within %0d", which, budget);
    end
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    step;
    step;
    resetn = 1'b1;
  endtask

  initial begin
    int n;
    int prev_start;
    int first;
    int pulses;
    int ready_seen;
    logic err_at;

    // reset state
    step;
    chk("rst_outs", 64'(|{req_ready, resp_done, resp_err, busy, dma_start_transfer,
                          dma_direction, dma_ddr_addr, dma_length_bytes}), 64'(0));
    chk("rst_job_count", 64'(job_count), 64'(0));
`ifdef DMA_ARB_TIMEOUT_EN
    chk("rst_timeout_hit", 64'(timeout_hit), 64'(0));
`endif
    resetn = 1'b1;
    step;

    // 1: single request
    shim_mode = 0; rise_at = 20;
    req_dir[0] = 1'b1;
    req_addr[31:0] = 32'h1000_0000;
    req_len[29:0] = 30'd4096;
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", 64'(req_ready), 64'(4'b0001));
    step;
    chk("t1_start", 64'(dma_start_transfer), 64'(1));
    chk("t1_addr", 64'(dma_ddr_addr), 64'(32'h1000_0000));
    chk("t1_len", 64'(dma_length_bytes), 64'(4096));
    chk("t1_dir", 64'(dma_direction), 64'(1));
    chk("t1_busy", 64'(busy), 64'(1));
    req_valid = '0;
    step;
    chk("t1_start_1cyc", 64'(dma_start_transfer), 64'(0));
    wait_sig(2, 40, n);
    chk("t1_resp_lat", 64'(n), 64'(20));
    chk("t1_resp_done", 64'(resp_done), 64'(4'b0001));
    chk("t1_resp_err", 64'(resp_err), 64'(0));
    step;
    chk("t1_job_count", 64'(job_count), 64'(1));
    chk("t1_busy_clr", 64'(busy), 64'(0));

    // 2: all requesters valid from reset -> 0,1,2,3,0
    do_reset;
    shim_mode = 0; rise_at = 6;
    for (int i = 0; i < NR; i++) begin
      req_addr[32*i +: 32] = 32'h2000_0000 + 32'(i) * 32'h100;
      req_len[30*i +: 30] = 30'(16 * (i + 1));
      req_dir[i] = 1'(i % 2);
    end
    req_valid = 4'hF;
    prev_start = 0;
    for (int g = 0; g < 5; g++) begin
      int id;
      id = g % NR;
      wait_sig(0, 20, n);
      chk($sformatf("t2_ready_g%0d", g), 64'(req_ready), 64'(1 << id));
      chk($sformatf("t2_ready_lat_g%0d", g), 64'(n), 64'((g == 0) ? 0 : 1));
      step;
      chk($sformatf("t2_start_g%0d", g), 64'(dma_start_transfer), 64'(1));
      chk($sformatf("t2_addr_g%0d", g), 64'(dma_ddr_addr), 64'(32'h2000_0000 + id * 32'h100));
      chk($sformatf("t2_len_g%0d", g), 64'(dma_length_bytes), 64'(16 * (id + 1)));
      chk($sformatf("t2_dir_g%0d", g), 64'(dma_direction), 64'(id % 2));
      if (g > 0) chk($sformatf("t2_start_gap_g%0d", g), 64'(cyc - prev_start), 64'(9));
      prev_start = cyc;
      if (g == 4) req_valid = '0;
      wait_sig(2, 30, n);
      chk($sformatf("t2_resp_g%0d", g), 64'(resp_done), 64'(1 << id));
      chk($sformatf("t2_resp_lat_g%0d", g), 64'(n), 64'(7));
    end
    step;
    chk("t2_job_count", 64'(job_count), 64'(5));

    // 3: stale done drops 3 cycles after start, rises 10 later; a withdrawn request issues nothing
    shim_mode = 0; rise_at = 13;
    req_valid = 4'b0010;
    #1;
    chk("t3_ready", 64'(req_ready), 64'(4'b0010));
    step;
    req_valid = '0;
    first = -1; pulses = 0; ready_seen = 0; err_at = 1'bx;
    for (int k = 1; k <= 25; k++) begin
      step;
      if (resp_done != '0) begin
        pulses++;
        if (first < 0) begin
          first = k;
          err_at = resp_err;
        end
      end
      if (req_ready != '0) ready_seen++;
      if (k == 3) req_valid = 4'b1000;
      if (k == 6) req_valid = '0;
    end
    chk("t3_resp_lat", 64'(first), 64'(14));
    chk("t3_resp_pulses", 64'(pulses), 64'(1));
    chk("t3_resp_err", 64'(err_at), 64'(0));
    chk("t3_withdrawn", 64'(ready_seen), 64'(0));
    chk("t3_job_count", 64'(job_count), 64'(6));

    // 4: done never clears -> error after CLR_WAIT_MAX, then next job served normally
    shim_mode = 1;
    req_valid = 4'b0100;
    #1;
    chk("t4_ready", 64'(req_ready), 64'(4'b0100));
    step;
    req_valid = '0;
    wait_sig(2, 30, n);
    chk("t4_resp_lat", 64'(n), 64'(9));
    chk("t4_resp_done", 64'(resp_done), 64'(4'b0100));
    chk("t4_resp_err", 64'(resp_err), 64'(1));
    step;
    chk("t4_idle_busy", 64'(busy), 64'(0));
    shim_mode = 0; rise_at = 6;
    req_valid = 4'b1000;
    #1;
    chk("t4_next_ready", 64'(req_ready), 64'(4'b1000));
    step;
    req_valid = '0;
    wait_sig(2, 30, n);
    chk("t4_next_lat", 64'(n), 64'(7));
    chk("t4_next_err", 64'(resp_err), 64'(0));
    step;
    chk("t4_job_count", 64'(job_count), 64'(8));

    // 5: reset during WAIT with requester 2 active
    rise_at = 30;
    req_valid = 4'b0100;
    #1;
    chk("t5_ready", 64'(req_ready), 64'(4'b0100));
    repeat (7) step;
    resetn = 1'b0;
    #1;
    chk("t5_rst_outs", 64'(|{req_ready, resp_done, resp_err, busy, dma_start_transfer,
                             dma_direction, dma_ddr_addr, dma_length_bytes}), 64'(0));
    chk("t5_rst_job_count", 64'(job_count), 64'(0));
    req_valid = 4'b0111;
    step;
    resetn = 1'b1;
    #1;
    chk("t5_lower_first", 64'(req_ready), 64'(4'b0001));
    resetn = 1'b0;
    req_valid = 4'b0100;
    step;
    resetn = 1'b1;
    #1;
    chk("t5_req2_only", 64'(req_ready), 64'(4'b0100));

`ifdef DMA_ARB_TIMEOUT_EN
    // 6: done never asserted -> watchdog fires after TIMEOUT_CYCLES in CLR/WAIT
    shim_mode = 2;
    step;
    req_valid = '0;
    wait_sig(2, 80, n);
    chk("t6_resp_lat", 64'(n), 64'(51));
    chk("t6_resp_err", 64'(resp_err), 64'(1));
    chk("t6_timeout_hit", 64'(timeout_hit), 64'(1));
    repeat (3) step;
    chk("t6_timeout_sticky", 64'(timeout_hit), 64'(1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dma_job_arbiter.md
Name: dma_job_arbiter

Overview:
Round-robin scheduler that shares the single axi_dma_shim "friendly" job interface (start/direction/address/length/done) among NUM_REQ requesters, e.g. the accelerator control, the PS mailbox and the self-test engine.
- Accepts one job descriptor per requester, serialises the jobs onto the shim and returns a per-requester completion pulse.
- Handles the shim's edge-detected start and its level done, which stays high until the next start.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
ID_W, 2, requester index width; must satisfy 2**ID_W >= NUM_REQ.
CLR_WAIT_MAX, 8, maximum cycles to wait for dma_transfer_done to drop after start.
TIMEOUT_CYCLES, 1000000, watchdog limit; used only with DMA_ARB_TIMEOUT_EN.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester job request, held until accepted
req_ready  out  NUM_REQ  one-hot acceptance strobe, 1 cycle
req_dir  in  NUM_REQ  per-requester direction, 1=MM2S 0=S2MM
req_addr  in  NUM_REQ*32  flattened DDR addresses; requester i is bits [32i+31:32i]
req_len  in  NUM_REQ*30  flattened byte lengths; requester i is bits [30i+29:30i]
resp_done  out  NUM_REQ  one-hot completion pulse, 1 cycle
resp_err  out  1  error flag, qualified by resp_done
busy  out  1  high from acceptance until the resp cycle
job_count  out  16  completed-job counter, wraps 0xFFFF->0
dma_start_transfer  out  1  to shim
dma_direction  out  1  to shim
dma_ddr_addr  out  32  to shim
dma_length_bytes  out  30  to shim
dma_transfer_done  in  1  from shim

Behaviour:
- Reset is asynchronous, active-low, on resetn; the clock is clk.
- Reset values: all outputs are 0, the FSM is in IDLE and the round-robin pointer last_gnt = NUM_REQ-1, so requester 0 has first priority.
- Arbitration (IDLE only):
  - The search starts at (last_gnt+1) mod NUM_REQ, increments with wrap, and the first requester with req_valid set wins.
  - On a win, that requester's req_ready pulses for 1 cycle in the same cycle.
  - Its dir, addr and len are latched into dma_direction, dma_ddr_addr and dma_length_bytes.
  - last_gnt <= winner, busy <= 1, state -> START.
  - No valid requester: the FSM stays in IDLE and all outputs hold.
- Shim outputs change only at acceptance and are held stable until the next acceptance.
- START: dma_start_transfer = 1 for exactly 1 cycle, then -> CLR.
- CLR:
  - Waits until dma_transfer_done == 0; the shim needs 3 cycles to clear a stale done.
  - Low seen -> WAIT.
  - If done is still high after CLR_WAIT_MAX cycles, resp_err = 1 and -> RESP.
- WAIT: dma_transfer_done == 1 -> RESP with resp_err = 0.
- RESP:
  - resp_done[granted] = 1 for 1 cycle and job_count increments (including error responses).
  - busy <= 0, -> IDLE.
  - The next acceptance occurs at the earliest in the cycle after RESP, so dma_start_transfer is low for at least 4 cycles between pulses, which the shim's edge detector requires.
- Simultaneous requests: the strict rotation grants each valid requester at most once per NUM_REQ grants.
- req_valid dropped before acceptance: the request is withdrawn and no job is issued.
- req_valid or input changes after acceptance have no effect on the running job.
- A requester may re-request in the cycle after its resp_done; it is served according to the rotation.
- req_len = 0 is forwarded unchanged; responding to zero-length jobs is the shim/DMA's responsibility.
- Reset mid-job: everything returns to reset values immediately. dma_start_transfer drops, and the shim is reset by the same resetn.
- Latency from req_valid to dma_start_transfer: 2 cycles (acceptance cycle, then START).

Optional Feature:
DMA_ARB_TIMEOUT_EN
- When defined:
  - A 32-bit watchdog counter clears on entry to CLR and counts in CLR and WAIT.
  - On reaching TIMEOUT_CYCLES it forces -> RESP with resp_err = 1.
  - A timeout_hit sticky output of width 1 is added; it is cleared only by reset.
- When undefined:
  - There is no counter, WAIT is unbounded and the timeout_hit port is absent.
  - resp_err is asserted only by the CLR_WAIT_MAX violation.

Test Plan:
1. Single request: req_valid[0] with dir=1, addr=0x1000_0000, len=4096. The shim model raises done 20 cycles after start → req_ready[0] at t0, start at t0+1 for 1 cycle, resp_done[0] with err=0, job_count=1.
2. All 4 requesters valid continuously after reset → grant order 0,1,2,3,0; each resp_done occurs before the next req_ready; start low for at least 4 cycles between pulses.
3. Stale done: the shim holds done=1 from the prior job, clears 3 cycles after start, then re-asserts 10 cycles later → exactly one resp_done, not an early one.
4. The shim never clears done → resp_err=1 with resp_done after CLR_WAIT_MAX=8 cycles in CLR; the FSM returns to IDLE and the next job is served.
5. resetn asserted during WAIT with requester 2 active → all outputs 0 immediately; after release, req_valid[2] is granted first only if no lower-rotation requester (0 or 1) is valid.
6. With DMA_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=50, done is never asserted → resp_err=1 at about 50 cycles after start, and timeout_hit=1 stays set.
